// File: rtl/fir_decim_fifo.sv
// Post-filter stage: discards pipeline-fill samples after reset, decimates the
// stream, and buffers kept samples in a first-word-fall-through FIFO.
module fir_decim_fifo #(
  parameter int DATA_W = 16,
  parameter int DECIM  = 2,
  parameter int SKIP   = 3,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int SK_W  = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(DECIM - 1);
  localparam logic [SK_W-1:0]  SK_INIT  = SK_W'(SKIP);

  logic [SK_W-1:0]   skip_r,   skip_s;
  logic [PH_W-1:0]   phase_r,  phase_s;
  logic [PTR_W-1:0]  wr_ptr_r, wr_ptr_s;
  logic [PTR_W-1:0]  rd_ptr_r, rd_ptr_s;
  logic [LVL_W-1:0]  level_r,  level_s;
  logic              valid_r,  valid_s;
  logic [DATA_W-1:0] data_r,   data_s;
  logic              ovf_r,    ovf_s;
  logic              kept_s, pop_s, push_s, drop_s, full_s;

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Skip/decimation gating: decides whether the current input sample is kept.
  always_comb begin
    skip_s  = skip_r;
    phase_s = phase_r;
    kept_s  = 1'b0;
    if (in_valid) begin
      if (skip_r != '0) begin
        skip_s = skip_r - SK_W'(1);
      end else begin
        kept_s = (phase_r == '0);
        if (phase_r == PH_LAST) begin
          phase_s = '0;
        end else begin
          phase_s = phase_r + PH_W'(1);
        end
      end
    end else begin
      skip_s  = skip_r;
      phase_s = phase_r;
    end
  end

  // FIFO bookkeeping and the next registered head; the head is taken from the
  // incoming sample when it lands in the slot the read pointer will point at.
  always_comb begin
    full_s   = (level_r == LVL_FULL);
    pop_s    = valid_r && out_ready;
    push_s   = kept_s && (!full_s || pop_s);
    drop_s   = kept_s && full_s && !pop_s;
    wr_ptr_s = push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
    rd_ptr_s = pop_s  ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;

    case ({push_s, pop_s})
      2'b10:   level_s = level_r + LVL_W'(1);
      2'b01:   level_s = level_r - LVL_W'(1);
      default: level_s = level_r;
    endcase

    if (drop_s) begin
      ovf_s = 1'b1;
    end else if (clr_ovf) begin
      ovf_s = 1'b0;
    end else begin
      ovf_s = ovf_r;
    end

    valid_s = (level_s != '0);
    if (!valid_s) begin
      data_s = '0;
    end else if (push_s && (wr_ptr_r == rd_ptr_s)) begin
      data_s = in_data;
    end else begin
      data_s = mem_r[rd_ptr_s];
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      skip_r   <= SK_INIT;
      phase_r  <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      valid_r  <= 1'b0;
      data_r   <= '0;
      ovf_r    <= 1'b0;
    end else begin
      skip_r   <= skip_s;
      phase_r  <= phase_s;
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      level_r  <= level_s;
      valid_r  <= valid_s;
      data_r   <= data_s;
      ovf_r    <= ovf_s;
    end
  end

  // Sample storage; contents are never visible before being written.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign level     = level_r;
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Scoreboard bench for fir_decim_fifo: directed scenarios then random traffic,
// checked every cycle against a queue-based reference model.
module tb_fir_decim_fifo;

  localparam int DATA_W = 16;
  localparam int DECIM  = 2;
  localparam int SKIP   = 3;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        level;
  logic              overflow;
  logic              clr_ovf = 1'b0;

  int tests = 0;
  int fails = 0;

  fir_decim_fifo #(.DATA_W(DATA_W), .DECIM(DECIM), .SKIP(SKIP), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: expected FIFO contents as a queue
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got[$];
  int  seen_m, post_m;
  bit  ovf_m, init_m = 1'b0;
  bit  pop_m, keep_m, drop_m;

  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      seen_m = 0;
      post_m = 0;
      ovf_m  = 1'b0;
      init_m = 1'b1;
    end else if (init_m) begin
      if (out_valid && out_ready) got.push_back(out_data);
      pop_m  = (exp_q.size() > 0) && out_ready;
      keep_m = 1'b0;
      drop_m = 1'b0;
      if (in_valid) begin
        if (seen_m < SKIP) seen_m++;
        else begin
          keep_m = ((post_m % DECIM) == 0);
          post_m++;
        end
      end
      if (pop_m) void'(exp_q.pop_front());
      if (keep_m) begin
        if (exp_q.size() == DEPTH) drop_m = 1'b1;
        else exp_q.push_back(in_data);
      end
      if (drop_m) ovf_m = 1'b1;
      else if (clr_ovf) ovf_m = 1'b0;
    end
  end

  // Monitor: compares DUT outputs with the model away from the active edge
  always @(negedge clk) begin
    if (init_m) begin
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("level", 32'(level), 32'(exp_q.size()));
      check("overflow", 32'(overflow), 32'(ovf_m));
      check("out_data", 32'(out_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
    end
  end

  task automatic drive(input logic r, input logic v, input logic [DATA_W-1:0] d,
                       input logic rdy, input logic clr);
    rst = r; in_valid = v; in_data = d; out_ready = rdy; clr_ovf = clr;
    @(negedge clk);
  endtask

  task automatic feed(input int from, input int upto, input logic rdy);
    for (int i = from; i <= upto; i++) drive(1'b1, 1'b1, DATA_W'(i), rdy, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    got.delete();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, rdy, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);

    // skip and decimate
    got.delete();
    feed(1, 11, 1'b1);
    idle(2, 1'b1);
    check("s1_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) check("s1_seq", 32'(got[i]), 32'(4 + 2 * i));
    end

    // overflow and drain
    do_reset();
    feed(1, 23, 1'b0);
    check("s2_level", 32'(level), 32'd8);
    check("s2_ovf", 32'(overflow), 32'd1);
    got.delete();
    idle(10, 1'b1);
    check("s2_drained", 32'(got.size()), 32'd8);
    if (got.size() == 8) check("s2_last", 32'(got[7]), 32'd18);
    check("s2_level0", 32'(level), 32'd0);
    check("s2_ovf_sticky", 32'(overflow), 32'd1);

    // full with simultaneous push and pop
    do_reset();
    feed(1, 19, 1'b0);
    check("s3_full", 32'(level), 32'd8);
    got.delete();
    drive(1'b1, 1'b1, 16'd20, 1'b1, 1'b0);
    check("s3_level", 32'(level), 32'd8);
    check("s3_ovf", 32'(overflow), 32'd0);
    idle(10, 1'b1);
    check("s3_count", 32'(got.size()), 32'd9);
    if (got.size() > 0) check("s3_last", 32'(got[got.size()-1]), 32'd20);

    // clear precedence
    do_reset();
    feed(1, 20, 1'b0);
    check("s4_set", 32'(overflow), 32'd1);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1);
    check("s4_clr", 32'(overflow), 32'd0);
    drive(1'b1, 1'b1, 16'd21, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'd22, 1'b0, 1'b1);
    check("s4_set_wins", 32'(overflow), 32'd1);

    // input gaps
    do_reset();
    feed(1, 3, 1'b0);
    drive(1'b1, 1'b1, 16'd10, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'd99, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'd99, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'd11, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 16'd12, 1'b0, 1'b0);
    check("s5_level", 32'(level), 32'd2);
    got.delete();
    idle(3, 1'b1);
    check("s5_count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check("s5_first", 32'(got[0]), 32'd10);
      check("s5_second", 32'(got[1]), 32'd12);
    end

    // reset mid-stream
    do_reset();
    feed(1, 21, 1'b0);
    idle(3, 1'b1);
    check("s6_level5", 32'(level), 32'd5);
    do_reset();
    check("s6_level", 32'(level), 32'd0);
    check("s6_valid", 32'(out_valid), 32'd0);
    check("s6_data", 32'(out_data), 32'd0);
    check("s6_ovf", 32'(overflow), 32'd0);
    feed(101, 104, 1'b0);
    check("s6_kept_level", 32'(level), 32'd1);
    check("s6_kept_data", 32'(out_data), 32'd104);

    // random traffic with occasional clears and resets
    for (int i = 0; i < 4000; i++) begin
      drive(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0),
            DATA_W'($urandom), (((i / 64) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0)),
            ($urandom_range(0, 31) == 0));
    end
    idle(12, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
